// File: rtl/data_memory_responder.sv
// Data-memory responder for the LEGv8 datapath: byte-addressed little-endian RAM
// with programmable read/write latency and a one-cycle ready/error handshake.
module data_memory_responder #(
  parameter int unsigned MEM_BYTES     = 256,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  inout  wire  [63:0] data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  output logic        ready,
  output logic        error
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] RD_M1 = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_M1 = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      be_q, be_d;
  logic [63:0]     wdata_q, wdata_d;
  logic            rd_q, rd_d;
  logic            err_q, err_d;

  logic [7:0]      mem_q [MEM_BYTES];
  logic [AW-1:0]   byte_idx [8];
  logic [7:0]      req_be;
  logic [2:0]      req_mask;
  logic [3:0]      req_nbytes;
  logic            req_misaligned;
  logic            req_out_of_range;
  logic [63:0]     rdata;
  logic            drive;

  always_comb begin
    req_be     = 8'h01;
    req_mask   = 3'b000;
    req_nbytes = 4'd1;
    case (size)
      2'b00: begin req_be = 8'h01; req_mask = 3'b000; req_nbytes = 4'd1; end
      2'b01: begin req_be = 8'h03; req_mask = 3'b001; req_nbytes = 4'd2; end
      2'b10: begin req_be = 8'h0F; req_mask = 3'b011; req_nbytes = 4'd4; end
      default: begin req_be = 8'hFF; req_mask = 3'b111; req_nbytes = 4'd8; end
    endcase
  end

  assign req_misaligned = (address[2:0] & req_mask) != 3'b000;
  // Full 33-bit compare so high address bits are rejected rather than wrapping.
  assign req_out_of_range = ({1'b0, address} + {29'd0, req_nbytes}) > 33'(MEM_BYTES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (mem_read && mem_write) begin
          rd_d    = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else if (mem_read ^ mem_write) begin
          addr_d  = address[AW-1:0];
          be_d    = req_be;
          wdata_d = data;
          rd_d    = mem_read;
          err_d   = req_misaligned | req_out_of_range;
          cnt_d   = mem_read ? RD_M1 : WR_M1;
          state_d = ((mem_read ? RD_M1 : WR_M1) == '0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!mem_read && !mem_write) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = RELEASE;
      RELEASE: if (!mem_read && !mem_write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
    addr_q  <= addr_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) byte_idx[i] = addr_q + AW'(i);
  end

  // Write commits on the edge closing RESP; a reset on that edge cancels it.
  always_ff @(posedge clock) begin
    if (reset && state_q == RESP && !rd_q && !err_q) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (be_q[i]) mem_q[byte_idx[i]] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (!err_q) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (be_q[i]) rdata[8*i +: 8] = mem_q[byte_idx[i]];
      end
    end
  end

  assign ready = (state_q == RESP);
  assign error = ready & err_q;
  assign drive = ready & rd_q;
  assign data  = drive ? rdata : 'z;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: expected responses are queued when a
// request is driven and compared when ready pulses.
module tb_data_memory_responder;

  localparam int unsigned MEM_BYTES = 256;
  localparam int unsigned RL = 2;
  // Write latency raised so a write spends cycles in BUSY for the mid-write reset case.
  localparam int unsigned WL = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        rd, wr;
  logic [1:0]  sz;
  logic [63:0] wd;
  logic        tb_drv;
  logic        ready, error;
  wire  [63:0] data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic        err;
    logic        chk_data;
    logic [63:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];

  assign data = tb_drv ? wd : 'z;

  data_memory_responder #(
    .MEM_BYTES    (MEM_BYTES),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clock    (clk),
    .reset    (rst_n),
    .address  (addr),
    .data     (data),
    .mem_read (rd),
    .mem_write(wr),
    .size     (sz),
    .ready    (ready),
    .error    (error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // A zero driven by the bench must read back as zero unless the DUT is also driving.
  task automatic probe_bus(input string tag);
    tb_drv = 1'b1;
    wd     = '0;
    #1;
    check(tag, data, 64'h0);
    tb_drv = 1'b0;
  endtask

  task automatic access(input string tag, input logic r, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic [63:0] d,
                        input logic exp_err, input logic [63:0] exp_rd);
    exp_t e;
    int   n;
    bit   got;
    e.tag      = tag;
    e.err      = exp_err;
    e.chk_data = r & ~w;
    e.rdata    = exp_rd;
    e.lat      = (r & w) ? 1 : (r ? int'(RL) : int'(WL));
    sb.push_back(e);
    @(negedge clk);
    rd = r; wr = w; addr = a; sz = s; wd = d; tb_drv = w;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        addr = ~a; sz = ~s;
        if (w) wd = ~d;
      end
      #1;
      if (ready) got = 1;
    end
    e = sb.pop_front();
    check({e.tag, "_ready"}, 64'(got), 64'd1);
    if (got) begin
      check({e.tag, "_lat"}, 64'(n), 64'(e.lat));
      check({e.tag, "_err"}, 64'(error), 64'(e.err));
      if (e.chk_data) check({e.tag, "_data"}, data, e.rdata);
    end
    rd = 0; wr = 0; tb_drv = 0;
    @(negedge clk);
    #1;
    check({e.tag, "_pulse"}, 64'(ready), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    exp_t e;
    int n;
    bit got;
    rst_n = 1'b0; rd = 0; wr = 0; addr = '0; sz = '0; wd = '0; tb_drv = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    probe_bus("rst_bus");
    pulses = 0;
    repeat (3) begin @(negedge clk); #1; if (ready) pulses++; end
    check("idle_quiet", 64'(pulses), 64'd0);

    access("wr_d24", 0, 1, 32'd24, 2'b11, 64'hFFFF_FFFF_FFFF_FFE8, 0, '0);
    access("rd_d24", 1, 0, 32'd24, 2'b11, '0, 0, 64'hFFFF_FFFF_FFFF_FFE8);
    access("rd_b24", 1, 0, 32'd24, 2'b00, '0, 0, 64'h0000_0000_0000_00E8);
    access("rd_h30", 1, 0, 32'd30, 2'b01, '0, 0, 64'h0000_0000_0000_FFFF);

    access("wr_misal", 0, 1, 32'd26, 2'b10, 64'h0, 1, '0);
    access("rd_after_misal", 1, 0, 32'd24, 2'b11, '0, 0, 64'hFFFF_FFFF_FFFF_FFE8);
    access("wr_oor", 0, 1, MEM_BYTES - 4, 2'b11, 64'h0, 1, '0);
    access("rd_oor", 1, 0, MEM_BYTES, 2'b11, '0, 1, 64'h0);
    access("rd_misal", 1, 0, 32'd25, 2'b01, '0, 1, 64'h0);
    access("rd_hiaddr", 1, 0, 32'h1000_0018, 2'b00, '0, 1, 64'h0);
    access("wr_top", 0, 1, MEM_BYTES - 8, 2'b11, 64'h0123_4567_89AB_CDEF, 0, '0);
    access("rd_top_b", 1, 0, MEM_BYTES - 1, 2'b00, '0, 0, 64'h01);
    access("rd_top_w", 1, 0, MEM_BYTES - 8, 2'b10, '0, 0, 64'h89AB_CDEF);

    // Read abandoned while BUSY.
    @(negedge clk);
    rd = 1; addr = 32'd24; sz = 2'b11;
    @(negedge clk);
    #1;
    check("abort_busy_ready", 64'(ready), 64'd0);
    rd = 0;
    pulses = 0;
    repeat (4) begin @(negedge clk); #1; if (ready) pulses++; end
    check("abort_quiet", 64'(pulses), 64'd0);
    probe_bus("abort_bus");
    access("after_abort", 1, 0, 32'd30, 2'b01, '0, 0, 64'hFFFF);

    access("both_hi", 1, 1, 32'd24, 2'b11, 64'h0, 1, '0);
    access("rd_after_both", 1, 0, 32'd24, 2'b11, '0, 0, 64'hFFFF_FFFF_FFFF_FFE8);

    // Reset lands while a write is still in BUSY.
    access("wr_d32", 0, 1, 32'd32, 2'b11, 64'hA5A5_A5A5_5A5A_5A5A, 0, '0);
    @(negedge clk);
    wr = 1; tb_drv = 1; addr = 32'd32; sz = 2'b11; wd = 64'h1234;
    @(negedge clk);
    rst_n = 0; wr = 0; tb_drv = 0;
    @(negedge clk);
    rst_n = 1;
    pulses = 0;
    repeat (5) begin @(negedge clk); #1; if (ready) pulses++; end
    check("rst_mid_quiet", 64'(pulses), 64'd0);
    probe_bus("rst_mid_bus");
    access("rd_d32", 1, 0, 32'd32, 2'b11, '0, 0, 64'hA5A5_A5A5_5A5A_5A5A);

    // Request held past ready: no second access until both lines drop.
    e.tag = "hold"; e.err = 0; e.chk_data = 1; e.rdata = 64'hE8; e.lat = int'(RL);
    sb.push_back(e);
    @(negedge clk);
    rd = 1; addr = 32'd24; sz = 2'b00;
    n = 0; got = 0;
    while (!got && n < 20) begin @(negedge clk); n++; #1; if (ready) got = 1; end
    e = sb.pop_front();
    check({e.tag, "_ready"}, 64'(got), 64'd1);
    check({e.tag, "_lat"}, 64'(n), 64'(e.lat));
    check({e.tag, "_data"}, data, e.rdata);
    addr = 32'd30; sz = 2'b01;
    pulses = 0;
    repeat (5) begin @(negedge clk); #1; if (ready) pulses++; end
    check("hold_quiet", 64'(pulses), 64'd0);
    rd = 0;
    @(negedge clk);
    @(negedge clk);
    access("after_hold", 1, 0, 32'd24, 2'b11, '0, 0, 64'hFFFF_FFFF_FFFF_FFE8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
